curve_const_rom: RTL and testbench
==================================

CURVE_CONST_ROM -- requirements
Module: curve_const_rom

Interface
REQ-001 Parameter WORD_W, default 32, output word width; SHALL divide 256; legal values 32, 64, 128, 256.
REQ-002 Derived constant NWORDS = 256/WORD_W, words per constant.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  1  constant-read request.
REQ-006 req_ready  out  1  block can accept a request.
REQ-007 req_sel  in  2  0=P (field prime), 1=GX (base-point x), 2=GY (base-point y), 3=reserved.
REQ-008 curve_sel  in  1  0=secp256k1, 1=P-256.
REQ-009 out_valid  out  1  out_data holds a valid word.
REQ-010 out_ready  in  1  consumer accepts the word.
REQ-011 out_data  out  WORD_W  constant word, least-significant word first.
REQ-012 out_last  out  1  marks the final word of a constant.
REQ-013 out_err  out  1  marks an error response.
REQ-014 carry_in_n  out  1  constant 0.
REQ-015 carry_in_2  out  1  constant 1.

Function
REQ-016 FSM states SHALL be IDLE and STREAM.
REQ-017 req_ready SHALL be 1 only in IDLE; a request is accepted on req_valid && req_ready.
REQ-018 On accept, req_sel and curve_sel SHALL be latched and the FSM SHALL move to STREAM; out_valid SHALL rise the next cycle (1-cycle latency).
REQ-019 secp256k1 constants: P=fffffffffffffffffffffffffffffffffffffffffffffffffffffffefffffc2f, GX=79be667ef9dcbbac55a06295ce870b07029bfcdb2dce28d959f2815b16f81798, GY=483ada7726a3c4655da4fbfc0e1108a8fd17b448a68554199c47d08ffb10d4b8.
REQ-020 Word k (k=0..NWORDS-1) SHALL be constant bits [k*WORD_W +: WORD_W].
REQ-021 The word index SHALL advance only on out_valid && out_ready; out_data, out_last and out_err SHALL hold stable while out_valid && !out_ready.
REQ-022 out_last SHALL be 1 exactly on word NWORDS-1; with WORD_W=256 every response is a single word with out_last=1.
REQ-023 A handshake on a word with out_last=1 SHALL return the FSM to IDLE; req_ready SHALL be 1 the following cycle, with no back-to-back accept in that handshake cycle.
REQ-024 req_sel=3 SHALL produce one all-zero word with out_last=1 and out_err=1.
REQ-025 out_err SHALL be 0 on all non-error words.
REQ-026 Request inputs SHALL be ignored in STREAM.

Reset
REQ-027 rst SHALL force IDLE, word index 0, out_valid=0, out_last=0, out_err=0, out_data=0 and req_ready=1 on the next edge, aborting any stream in progress without completing it.
REQ-028 carry_in_n and carry_in_2 SHALL be unaffected by rst.

Configuration
REQ-029 Macro CURVE_CONST_P256_EN defined: curve_sel=1 SHALL stream P-256 constants P=ffffffff00000001000000000000000000000000ffffffffffffffffffffffff, GX=6b17d1f2e12c4247f8bce6e563a440f277037d812deb33a0f4a13945d898c296, GY=4fe342e2fe1a7f9b8ee7eb4a7c0f9e162bce33576b315ececbb6406837bf51f5.
REQ-030 Macro not defined: a request with curve_sel=1 SHALL be answered like req_sel=3 (one zero word, out_last=1, out_err=1), and no P-256 constants SHALL be synthesised.

Structure
REQ-031 Package curve_const_pkg SHALL hold the 256-bit curve constants, the req_sel enumeration (SEL_P, SEL_GX, SEL_GY, SEL_RSVD) and the FSM state typedef.
REQ-032 Sub-module curve_const_mux SHALL combinationally select the 256-bit constant and error flag from the latched selects; curve_const_rom holds the FSM and word slicing.

Verification
REQ-033 WORD_W=32, secp256k1, sel=P, out_ready=1 -> 8 words on consecutive cycles, word0=fffffc2f, word1=fffffffe, word7=ffffffff with out_last=1; req_ready=1 the cycle after.
REQ-034 WORD_W=64, sel=GX, out_ready toggled 1/0 -> words 59f2815b16f81798, 029bfcdb2dce28d9, 55a06295ce870b07, 79be667ef9dcbbac, each held stable while stalled.
REQ-035 sel=3 -> single word 0 with out_last=1, out_err=1; then sel=GY with WORD_W=256 -> one word 483ada...d4b8 with out_err=0.
REQ-036 rst asserted after word 2 of a 32-bit GY stream -> out_valid=0 and req_ready=1 next cycle; a new P request then streams from word0=fffffc2f.
REQ-037 curve_sel=1, sel=P, WORD_W=32: with CURVE_CONST_P256_EN -> word0=ffffffff, word3=00000000, word6=00000001, word7=ffffffff; without it -> single zero word, out_err=1.

Source files
------------

// File: rtl/curve_const_pkg.sv
//==============================================================================
// Module      : curve_const_pkg
// Description : Shared definitions for the elliptic-curve constant ROM:
//               256-bit curve constants, request-select encoding and the
//               streaming FSM state type.
//               P-256 constants exist only when CURVE_CONST_P256_EN is defined.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package curve_const_pkg;

    // secp256k1 field prime and base point
    localparam logic [255:0] C_SECP_P  =
        256'hffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_fffffffe_fffffc2f;
    localparam logic [255:0] C_SECP_GX =
        256'h79be667e_f9dcbbac_55a06295_ce870b07_029bfcdb_2dce28d9_59f2815b_16f81798;
    localparam logic [255:0] C_SECP_GY =
        256'h483ada77_26a3c465_5da4fbfc_0e1108a8_fd17b448_a6855419_9c47d08f_fb10d4b8;

`ifdef CURVE_CONST_P256_EN
    // NIST P-256 field prime and base point
    localparam logic [255:0] C_P256_P  =
        256'hffffffff_00000001_00000000_00000000_00000000_ffffffff_ffffffff_ffffffff;
    localparam logic [255:0] C_P256_GX =
        256'h6b17d1f2_e12c4247_f8bce6e5_63a440f2_77037d81_2deb33a0_f4a13945_d898c296;
    localparam logic [255:0] C_P256_GY =
        256'h4fe342e2_fe1a7f9b_8ee7eb4a_7c0f9e16_2bce3357_6b315ece_cbb64068_37bf51f5;
`endif

    // Which constant of the selected curve is requested
    typedef enum logic [1:0] {
        SEL_P    = 2'd0,
        SEL_GX   = 2'd1,
        SEL_GY   = 2'd2,
        SEL_RSVD = 2'd3
    } sel_e;

    // Streaming FSM states
    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

endpackage

`default_nettype wire

// File: rtl/curve_const_mux.sv
//==============================================================================
// Module      : curve_const_mux
// Description : Combinational selection of the 256-bit constant and the error
//               flag from the latched constant/curve selects.
//               CURVE_CONST_P256_EN adds the P-256 constant set; without it a
//               P-256 request is reported as an error with a zero constant.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module curve_const_mux
    import curve_const_pkg::*;
(
    input  logic [1:0]   sel,
    input  logic         curve,
    output logic [255:0] const_val,
    output logic         err
);

    // Pick the constant; unknown selects or unsupported curves give zero + err
    always_comb begin
        const_val = '0;
        err       = 1'b0;
`ifdef CURVE_CONST_P256_EN
        if (curve) begin
            case (sel_e'(sel))
                SEL_P:   const_val = C_P256_P;
                SEL_GX:  const_val = C_P256_GX;
                SEL_GY:  const_val = C_P256_GY;
                default: err       = 1'b1;
            endcase
        end else begin
            case (sel_e'(sel))
                SEL_P:   const_val = C_SECP_P;
                SEL_GX:  const_val = C_SECP_GX;
                SEL_GY:  const_val = C_SECP_GY;
                default: err       = 1'b1;
            endcase
        end
`else
        if (curve) begin
            err = 1'b1;
        end else begin
            case (sel_e'(sel))
                SEL_P:   const_val = C_SECP_P;
                SEL_GX:  const_val = C_SECP_GX;
                SEL_GY:  const_val = C_SECP_GY;
                default: err       = 1'b1;
            endcase
        end
`endif
    end

endmodule

`default_nettype wire

// File: rtl/curve_const_rom.sv
//==============================================================================
// Module      : curve_const_rom
// Description : Streams a 256-bit elliptic-curve constant as NWORDS words of
//               WORD_W bits, least-significant word first, over a
//               valid/ready interface. Error responses are one zero word.
//               Optional feature macro: CURVE_CONST_P256_EN (P-256 constants).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module curve_const_rom
    import curve_const_pkg::*;
#(
    // Must divide 256: one of 32, 64, 128, 256
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_sel,
    input  logic              curve_sel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_last,
    output logic              out_err,
    output logic              carry_in_n,
    output logic              carry_in_2
);

    localparam int NWORDS = 256 / WORD_W;
    localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    state_e             r_state;
    state_e             w_next_state;
    logic [1:0]         r_sel;
    logic               r_curve;
    logic [IDX_W-1:0]   r_idx;

    logic [255:0]       w_const;
    logic               w_err;
    logic               w_accept;
    logic               w_fire;
    logic               w_last;
    logic [WORD_W-1:0]  w_word;

    // Fixed carry-in strap values, independent of reset
    assign carry_in_n = 1'b0;
    assign carry_in_2 = 1'b1;

    curve_const_mux u_mux (
        .sel       (r_sel),
        .curve     (r_curve),
        .const_val (w_const),
        .err       (w_err)
    );

    // Word slicing: error responses are a single word, so they are always last
    generate
        if (NWORDS > 1) begin : g_multi
            logic [NWORDS-1:0][WORD_W-1:0] w_words;
            assign w_words = w_const;
            assign w_word  = w_words[r_idx];
        end else begin : g_single
            assign w_word = w_const;
        end
    endgenerate

    assign w_last    = w_err || (r_idx == LAST_IDX);
    assign req_ready = (r_state == IDLE);
    assign out_valid = (r_state == STREAM);
    assign w_accept  = req_valid && req_ready;
    assign w_fire    = out_valid && out_ready;

    // Outputs read as zero whenever no word is being presented
    assign out_data  = out_valid ? w_word : '0;
    assign out_last  = out_valid && w_last;
    assign out_err   = out_valid && w_err;

    // Next-state: accept in IDLE, return to IDLE when the last word is taken
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (req_valid) w_next_state = STREAM;
            STREAM:  if (w_fire && w_last) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // State, latched selects and word index registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_sel   <= 2'd0;
            r_curve <= 1'b0;
            r_idx   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_sel   <= req_sel;
                r_curve <= curve_sel;
                r_idx   <= '0;
            end else if (w_fire) begin
                r_idx   <= w_last ? '0 : r_idx + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_curve_const_rom.sv
//==============================================================================
// Module      : tb_curve_const_rom
// Description : Self-checking bench for curve_const_rom at WORD_W 32/64/256,
//               using a 256-bit constant table with shift/mask word extraction
//               as the reference. Honours CURVE_CONST_P256_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_curve_const_rom;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [2:0]   rv, csel, ordy;
    logic [1:0]   rs [3];
    logic [2:0]   rr, ov, ol, oe, cn, c2;
    logic [31:0]  d0;
    logic [63:0]  d1;
    logic [255:0] d2;

    curve_const_rom #(.WORD_W(32)) u_w32 (
        .clk(clk), .rst(rst), .req_valid(rv[0]), .req_ready(rr[0]), .req_sel(rs[0]),
        .curve_sel(csel[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(d0),
        .out_last(ol[0]), .out_err(oe[0]), .carry_in_n(cn[0]), .carry_in_2(c2[0]));
    curve_const_rom #(.WORD_W(64)) u_w64 (
        .clk(clk), .rst(rst), .req_valid(rv[1]), .req_ready(rr[1]), .req_sel(rs[1]),
        .curve_sel(csel[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(d1),
        .out_last(ol[1]), .out_err(oe[1]), .carry_in_n(cn[1]), .carry_in_2(c2[1]));
    curve_const_rom #(.WORD_W(256)) u_w256 (
        .clk(clk), .rst(rst), .req_valid(rv[2]), .req_ready(rr[2]), .req_sel(rs[2]),
        .curve_sel(csel[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(d2),
        .out_last(ol[2]), .out_err(oe[2]), .carry_in_n(cn[2]), .carry_in_2(c2[2]));

    int           cur;
    logic [255:0] obs_data;
    always_comb begin
        case (cur)
            0:       obs_data = {224'd0, d0};
            1:       obs_data = {192'd0, d1};
            default: obs_data = d2;
        endcase
    end

    int           n_err = 0;
    int           n_chk = 0;
    logic [255:0] cap [8];
    logic         cap_err, cap_last;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int width_of(input int d);
        return (d == 0) ? 32 : (d == 1) ? 64 : 256;
    endfunction

    // Reference: {err, constant} straight from the published curve values
    function automatic logic [256:0] ref_const(input logic c, input logic [1:0] s);
        logic [255:0] v;
        logic         e;
        v = '0;
        e = 1'b0;
        if (s == 2'd3) e = 1'b1;
        else if (!c) begin
            if (s == 2'd0) v = 256'hfffffffffffffffffffffffffffffffffffffffffffffffffffffffefffffc2f;
            if (s == 2'd1) v = 256'h79be667ef9dcbbac55a06295ce870b07029bfcdb2dce28d959f2815b16f81798;
            if (s == 2'd2) v = 256'h483ada7726a3c4655da4fbfc0e1108a8fd17b448a68554199c47d08ffb10d4b8;
        end else begin
`ifdef CURVE_CONST_P256_EN
            if (s == 2'd0) v = 256'hffffffff00000001000000000000000000000000ffffffffffffffffffffffff;
            if (s == 2'd1) v = 256'h6b17d1f2e12c4247f8bce6e563a440f277037d812deb33a0f4a13945d898c296;
            if (s == 2'd2) v = 256'h4fe342e2fe1a7f9b8ee7eb4a7c0f9e162bce33576b315ececbb6406837bf51f5;
`else
            e = 1'b1;
`endif
        end
        return {e, v};
    endfunction

    task automatic set_req(input int d, input logic v, input logic [1:0] s, input logic c);
        rv[d]   = v;
        rs[d]   = s;
        csel[d] = c;
    endtask

    // mode: 0 always ready, 1 alternate stall/ready, 2 random; max_words 0 = full
    task automatic do_stream(input int d, input logic [1:0] s, input logic c,
                             input int mode, input int max_words);
        logic [256:0] r;
        logic [255:0] m;
        logic [255:0] exp;
        int           w, nw, stop, k, cyc;
        logic         rdy;
        r    = ref_const(c, s);
        w    = width_of(d);
        nw   = r[256] ? 1 : 256 / w;
        stop = (max_words > 0) ? max_words : nw;
        m    = '1;
        m    = m >> (256 - w);
        cur  = d;
        @(negedge clk);
        check("idle_req_ready", {255'd0, rr[d]}, 256'd1);
        check("idle_out_valid", {255'd0, ov[d]}, 256'd0);
        set_req(d, 1'b1, s, c);
        @(posedge clk);
        #1;
        set_req(d, 1'b0, 2'($urandom), 1'($urandom));
        k   = 0;
        cyc = 0;
        while (k < stop && cyc < 300) begin
            @(negedge clk);
            cyc++;
            exp = (r[255:0] >> (k * w)) & m;
            check("out_valid", {255'd0, ov[d]}, 256'd1);
            check("busy_req_ready", {255'd0, rr[d]}, 256'd0);
            check("out_data", obs_data, exp);
            check("out_last", {255'd0, ol[d]}, {255'd0, (k == nw - 1)});
            check("out_err", {255'd0, oe[d]}, {255'd0, r[256]});
            cap[k]   = obs_data;
            cap_err  = oe[d];
            cap_last = ol[d];
            if (mode == 0)      rdy = 1'b1;
            else if (mode == 1) rdy = (cyc % 2 == 0);
            else                rdy = 1'($urandom_range(0, 1));
            ordy[d] = rdy;
            set_req(d, 1'($urandom_range(0, 1)), 2'($urandom), 1'($urandom));
            @(posedge clk);
            if (rdy) k++;
        end
        if (k < stop) check("stream_timeout", 256'(k), 256'(stop));
        @(negedge clk);
        ordy[d] = 1'b0;
        set_req(d, 1'b0, 2'd0, 1'b0);
        if (max_words == 0) begin
            check("done_out_valid", {255'd0, ov[d]}, 256'd0);
            check("done_req_ready", {255'd0, rr[d]}, 256'd1);
        end
    endtask

    initial begin
        rv   = '0;
        csel = '0;
        ordy = '0;
        for (int i = 0; i < 3; i++) rs[i] = 2'd0;
        cur = 0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", {253'd0, rr}, {253'd0, 3'b111});
        check("rst_out_valid", {253'd0, ov}, 256'd0);
        check("rst_out_last", {253'd0, ol}, 256'd0);
        check("rst_out_err", {253'd0, oe}, 256'd0);
        check("rst_data32", {224'd0, d0}, 256'd0);
        check("rst_data64", {192'd0, d1}, 256'd0);
        check("rst_data256", d2, 256'd0);
        check("carry_n_rst", {253'd0, cn}, 256'd0);
        check("carry_2_rst", {253'd0, c2}, {253'd0, 3'b111});
        @(negedge clk);
        rst = 1'b0;

        // 32-bit secp256k1 P, no back-pressure
        do_stream(0, 2'd0, 1'b0, 0, 0);
        check("p32_w0", cap[0], 256'hfffffc2f);
        check("p32_w1", cap[1], 256'hfffffffe);
        check("p32_w7", cap[7], 256'hffffffff);
        check("p32_w7_last", {255'd0, cap_last}, 256'd1);

        // 64-bit GX with alternating stalls
        do_stream(1, 2'd1, 1'b0, 1, 0);
        check("gx64_w0", cap[0], 256'h59f2815b16f81798);
        check("gx64_w1", cap[1], 256'h029bfcdb2dce28d9);
        check("gx64_w2", cap[2], 256'h55a06295ce870b07);
        check("gx64_w3", cap[3], 256'h79be667ef9dcbbac);

        // Reserved select, then a full-width GY
        do_stream(0, 2'd3, 1'b0, 2, 0);
        check("rsvd_data", cap[0], 256'd0);
        check("rsvd_err", {255'd0, cap_err}, 256'd1);
        check("rsvd_last", {255'd0, cap_last}, 256'd1);
        do_stream(2, 2'd2, 1'b0, 0, 0);
        check("gy256", cap[0],
              256'h483ada7726a3c4655da4fbfc0e1108a8fd17b448a68554199c47d08ffb10d4b8);
        check("gy256_err", {255'd0, cap_err}, 256'd0);

        // Abort a 32-bit GY stream after word 2 with reset
        do_stream(0, 2'd2, 1'b0, 0, 3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_out_valid", {255'd0, ov[0]}, 256'd0);
        check("abort_req_ready", {255'd0, rr[0]}, 256'd1);
        check("abort_data", {224'd0, d0}, 256'd0);
        check("abort_last_err", {254'd0, ol[0], oe[0]}, 256'd0);
        check("abort_carry", {254'd0, cn[0], c2[0]}, 256'd1);
        @(negedge clk);
        rst = 1'b0;
        do_stream(0, 2'd0, 1'b0, 0, 0);
        check("after_abort_w0", cap[0], 256'hfffffc2f);

        // P-256 P at 32 bits
        do_stream(0, 2'd0, 1'b1, 0, 0);
`ifdef CURVE_CONST_P256_EN
        check("p256_w0", cap[0], 256'hffffffff);
        check("p256_w3", cap[3], 256'h00000000);
        check("p256_w6", cap[6], 256'h00000001);
        check("p256_w7", cap[7], 256'hffffffff);
`else
        check("p256_off_data", cap[0], 256'd0);
        check("p256_off_err", {255'd0, cap_err}, 256'd1);
`endif

        // Random requests with random back-pressure across all widths
        for (int i = 0; i < 24; i++) begin
            do_stream(int'($urandom_range(0, 2)), 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), 2, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
